// File: rtl/uart_par_pkg.sv
// Shared encodings and the parity selection helper for the serial parity engine.
package uart_par_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_READY = 2'b10
  } state_e;

  // acc is the XOR of all data bits seen in the frame.
  function automatic logic par_of(input logic acc, input par_typ_e typ);
    logic p;
    p = 1'b0;
    case (typ)
      PAR_EVEN:  p = acc;
      PAR_ODD:   p = ~acc;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle wins and
// restarts the count at one.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  input  logic             CLR,
  output logic [WIDTH-1:0] CNT
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC) begin
      if (CLR) begin
        cnt_d = WIDTH'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else if (CLR) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/parity_engine.sv
// Serial parity generator/checker: accumulates parity bit by bit over a runtime-selected
// frame length and checks received parity bits with sticky flag and saturating count.
module parity_engine
  import uart_par_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ERR_CNT_W  = 8,
  localparam int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [1:0]           PAR_TYP,
  input  logic [LEN_W-1:0]     DATA_LEN,
  input  logic                 START,
  input  logic                 BIT_VLD,
  input  logic                 BIT_IN,
  input  logic                 CHK_VLD,
  input  logic                 CHK_BIT,
  input  logic                 CLR_ERR,
  output logic                 PAR_Bit,
  output logic                 PAR_RDY,
  output logic                 BUSY,
  output logic                 PAR_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  state_e           state_q, state_d;
  par_typ_e         typ_q;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_inc, len_in;
  logic             acc_q, par_q, err_q;
  logic             busy_q, busy_d, rdy_q, rdy_d;
  logic             start_ok, bit_ok, chk_ok, last_bit, mismatch;

  // START outranks the other strobes; EN gates everything except CLR_ERR.
  always_comb begin
    start_ok = EN & START;
    bit_ok   = EN & BIT_VLD & ~START & (state_q == S_ACCUM);
    chk_ok   = EN & CHK_VLD & ~START & (state_q == S_READY);
    cnt_inc  = cnt_q + LEN_W'(1);
    last_bit = bit_ok & (cnt_inc == len_q);
    mismatch = chk_ok & (CHK_BIT != par_q);
    len_in   = ((DATA_LEN == '0) || (DATA_LEN > LEN_W'(DATA_WIDTH))) ? LEN_W'(DATA_WIDTH)
                                                                      : DATA_LEN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_ok) begin
      state_d = S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: if (last_bit) state_d = S_READY;
        S_READY: if (chk_ok)   state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Flags are decoded from the next state so the outputs come straight from flops.
  always_comb begin
    busy_d = (state_d == S_ACCUM);
    rdy_d  = (state_d == S_READY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      typ_q <= PAR_EVEN;
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      par_q <= 1'b0;
    end else if (start_ok) begin
      typ_q <= par_typ_e'(PAR_TYP);
      len_q <= len_in;
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else if (bit_ok) begin
      cnt_q <= cnt_inc;
      acc_q <= acc_q ^ BIT_IN;
      if (last_bit) par_q <= par_of(acc_q ^ BIT_IN, typ_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end else if (CLR_ERR) begin
      err_q <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .CLK (CLK),
    .RST (RST),
    .INC (mismatch),
    .CLR (CLR_ERR),
    .CNT (ERR_CNT)
  );

  assign PAR_Bit = par_q;
  assign PAR_RDY = rdy_q;
  assign BUSY    = busy_q;
  assign PAR_ERR = err_q;

endmodule
